// File: rtl/mlp_stream_ctrl.sv
// mlp_stream_ctrl: sequences one MLP job (two passes) between a 32-bit word
// memory and the int8 MLP accelerator. Each pass kicks the accelerator,
// streams 1104 words (ifmap, weights, bias) and collects 64 ofmap words.
// mode 0: two independent 64x64 layers. mode 1: one 128-input layer in two
// halves, with the pass-0 partial sums re-read as the pass-1 bias.
// Optional collect watchdog: define MLP_WDOG_EN.
module mlp_stream_ctrl #(
  parameter int unsigned     AW          = 12,
  parameter logic [AW-1:0]   IFMAP_BASE  = 12'h000,
  parameter logic [AW-1:0]   WEIGHT_BASE = 12'h020,
  parameter logic [AW-1:0]   BIAS_BASE   = 12'h820,
  parameter logic [AW-1:0]   OUT_BASE    = 12'h8A0,
  parameter int unsigned     WDOG_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [31:0]   mem_rdata,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic [31:0]   mem_wdata,
  output logic          acc_ready,
  output logic          acc_i_en,
  output logic [31:0]   acc_data_in,
  input  logic          acc_valid,
  input  logic [31:0]   acc_ofmap
);

  localparam logic [10:0] LOAD_WORDS = 11'd1104;

  if (WDOG_CYCLES < 2) begin : g_wdog_range
    $error("WDOG_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_KICK, S_LOAD, S_DRAIN, S_COLLECT, S_NEXT, S_FIN
  } state_t;

  state_t      state;
  logic        mode_q;
  logic        pass;
  logic [10:0] cnt;
  logic [5:0]  idx;

`ifdef MLP_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog;
  logic              err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Read data goes straight to the accelerator one cycle after the read; only
  // the strobe is registered (acc_i_en follows mem_rd_en), so the stream has
  // no bubbles and data_in is zero whenever the strobe is low.
  assign acc_data_in = acc_i_en ? mem_rdata : '0;

  // Stream word c of pass p: ifmap, then weights, then bias.
  function automatic logic [AW-1:0] rd_addr_of(input logic [10:0] c,
                                               input logic p,
                                               input logic m);
    logic [9:0]    k;
    logic [5:0]    b;
    logic [AW-1:0] a;
    k = 10'(c - 11'd16);
    b = 6'(c - 11'd1040);
    if (c < 11'd16)
      a = IFMAP_BASE + AW'({p, c[3:0]});
    else if (c < 11'd1040)
      a = m ? WEIGHT_BASE + AW'({k[9:4], p, k[3:0]})
            : WEIGHT_BASE + AW'({p, k});
    else if (m)
      a = p ? OUT_BASE + AW'(b) : BIAS_BASE + AW'(b);
    else
      a = BIAS_BASE + AW'({p, b});
    return a;
  endfunction

  // Job sequencer with registered control, memory and accelerator outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mode_q      <= 1'b0;
      pass        <= 1'b0;
      cnt         <= '0;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wdata   <= '0;
      acc_ready   <= 1'b0;
      acc_i_en    <= 1'b0;
`ifdef MLP_WDOG_EN
      wdog        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      done      <= 1'b0;
      acc_ready <= 1'b0;
      mem_wr_en <= 1'b0;
      acc_i_en  <= mem_rd_en;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            pass   <= 1'b0;
            busy   <= 1'b1;
`ifdef MLP_WDOG_EN
            err_q  <= 1'b0;
`endif
            state  <= S_ARM;
          end
        end
        S_ARM: begin
          if (!acc_valid) begin
            acc_ready <= 1'b1;
            state     <= S_KICK;
          end
        end
        S_KICK: begin
          mem_rd_en   <= 1'b1;
          mem_rd_addr <= rd_addr_of(11'd0, pass, mode_q);
          cnt         <= 11'd1;
          state       <= S_LOAD;
        end
        S_LOAD: begin
          if (cnt == LOAD_WORDS) begin
            mem_rd_en <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            mem_rd_addr <= rd_addr_of(cnt, pass, mode_q);
            cnt         <= cnt + 11'd1;
          end
        end
        S_DRAIN: begin
          idx   <= '0;
`ifdef MLP_WDOG_EN
          wdog  <= '0;
`endif
          state <= S_COLLECT;
        end
        S_COLLECT: begin
          if (acc_valid) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= OUT_BASE + AW'({pass, idx});
            mem_wdata   <= acc_ofmap;
            idx         <= idx + 6'd1;
`ifdef MLP_WDOG_EN
            wdog        <= '0;
`endif
            if (idx == 6'd63)
              state <= pass ? S_FIN : S_NEXT;
          end
`ifdef MLP_WDOG_EN
          else if (wdog == WDOG_W'(WDOG_CYCLES - 1)) begin
            err_q <= 1'b1;
            state <= S_FIN;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        S_NEXT: begin
          pass  <= 1'b1;
          state <= S_ARM;
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
